// File: rtl/row_sequencer.sv
// +----------------------------------------------------------------------------+
// | row_sequencer: double-buffered per-row trace results with texv DDA.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module row_sequencer #(
    parameter int H_VIEW = 640,
    parameter int FRAC   = 10
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                line_start,
    input  logic                pix_en,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic                ld_side,
    input  logic [10:0]         ld_size,
    input  logic [5:0]          ld_texu,
    input  logic [6+FRAC-1:0]   ld_texv_init,
    input  logic [6+FRAC-1:0]   ld_texv_step,
    output logic                row_valid,
    output logic                side,
    output logic [10:0]         size,
    output logic [5:0]          texu,
    output logic [5:0]          texv,
    output logic [7:0]          underruns
);

    localparam int         ACC_W     = 6 + FRAC;
    localparam logic [9:0] PIX_LIMIT = 10'(H_VIEW);

    logic               pend_valid_q, pend_valid_d;
    logic               pend_side_q,  pend_side_d;
    logic [10:0]        pend_size_q,  pend_size_d;
    logic [5:0]         pend_texu_q,  pend_texu_d;
    logic [ACC_W-1:0]   pend_init_q,  pend_init_d;
    logic [ACC_W-1:0]   pend_step_q,  pend_step_d;

    logic               row_valid_q,  row_valid_d;
    logic               side_q,       side_d;
    logic [10:0]        size_q,       size_d;
    logic [5:0]         texu_q,       texu_d;
    logic [ACC_W-1:0]   step_q,       step_d;
    logic [ACC_W-1:0]   acc_q,        acc_d;
    logic [9:0]         pix_cnt_q,    pix_cnt_d;
    logic [7:0]         underruns_q,  underruns_d;

    logic               w_load;

    assign w_load = ld_valid && !pend_valid_q;

    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_side_d  = pend_side_q;
        pend_size_d  = pend_size_q;
        pend_texu_d  = pend_texu_q;
        pend_init_d  = pend_init_q;
        pend_step_d  = pend_step_q;
        row_valid_d  = row_valid_q;
        side_d       = side_q;
        size_d       = size_q;
        texu_d       = texu_q;
        step_d       = step_q;
        acc_d        = acc_q;
        pix_cnt_d    = pix_cnt_q;
        underruns_d  = underruns_q;

        // A load only happens into an empty pending slot, so it never races the swap below.
        if (w_load) begin
            pend_valid_d = 1'b1;
            pend_side_d  = ld_side;
            pend_size_d  = ld_size;
            pend_texu_d  = ld_texu;
            pend_init_d  = ld_texv_init;
            pend_step_d  = ld_texv_step;
        end

        if (line_start) begin
            pix_cnt_d = '0;
            if (pend_valid_q) begin
                pend_valid_d = 1'b0;
                row_valid_d  = 1'b1;
                side_d       = pend_side_q;
                size_d       = pend_size_q;
                texu_d       = pend_texu_q;
                step_d       = pend_step_q;
                acc_d        = pend_init_q;
            end else begin
                row_valid_d = 1'b0;
                size_d      = '0;
                acc_d       = '0;
                if (underruns_q != 8'hFF) begin
                    underruns_d = underruns_q + 8'd1;
                end
            end
        end else if (pix_en && row_valid_q && (pix_cnt_q < PIX_LIMIT)) begin
            acc_d     = acc_q + step_q;
            pix_cnt_d = pix_cnt_q + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend_valid_q <= 1'b0;
            pend_side_q  <= 1'b0;
            pend_size_q  <= '0;
            pend_texu_q  <= '0;
            pend_init_q  <= '0;
            pend_step_q  <= '0;
            row_valid_q  <= 1'b0;
            side_q       <= 1'b0;
            size_q       <= '0;
            texu_q       <= '0;
            step_q       <= '0;
            acc_q        <= '0;
            pix_cnt_q    <= '0;
            underruns_q  <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_side_q  <= pend_side_d;
            pend_size_q  <= pend_size_d;
            pend_texu_q  <= pend_texu_d;
            pend_init_q  <= pend_init_d;
            pend_step_q  <= pend_step_d;
            row_valid_q  <= row_valid_d;
            side_q       <= side_d;
            size_q       <= size_d;
            texu_q       <= texu_d;
            step_q       <= step_d;
            acc_q        <= acc_d;
            pix_cnt_q    <= pix_cnt_d;
            underruns_q  <= underruns_d;
        end
    end

    assign ld_ready  = !pend_valid_q;
    assign row_valid = row_valid_q;
    assign side      = side_q;
    assign size      = size_q;
    assign texu      = texu_q;
    assign texv      = acc_q[FRAC+5:FRAC];
    assign underruns = underruns_q;

endmodule

`default_nettype wire
